// File: rtl/pc_fetch_unit.sv
// Architectural fetch PC and one-per-cycle instruction-fetch request generator.
// Define PC_TRAP_EN to add trap entry/return (trap_valid, trap_pc, mret_valid, epc).
module pc_fetch_unit #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     STEP         = 4,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            reset,
   output logic            fetch_valid,
   input  logic            fetch_ready,
   output logic [XLEN-1:0] fetch_addr,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            flush,
   input  logic            halt,
   output logic            halted,
   output logic            misaligned
`ifdef PC_TRAP_EN
   ,
   input  logic            trap_valid,
   input  logic [XLEN-1:0] trap_pc,
   input  logic            mret_valid,
   output logic [XLEN-1:0] epc
`endif
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

   localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            fetch_valid_q, fetch_valid_d;
   logic            flush_q, flush_d;
   logic            halted_q, halted_d;
   logic            misaligned_q, misaligned_d;
   logic            accept;
   logic            tgt_misaligned;
`ifdef PC_TRAP_EN
   logic [XLEN-1:0] epc_q, epc_d;
`endif

   assign accept         = fetch_valid_q & fetch_ready;
   assign tgt_misaligned = (redirect_target & ALIGN_MASK) != '0;

   always_comb begin
      pc_d         = pc_q;
      flush_d      = 1'b0;
      misaligned_d = 1'b0;
      state_d      = state_q;
`ifdef PC_TRAP_EN
      epc_d        = epc_q;
      // Fixed priority: trap > mret > redirect; a misaligned redirect becomes a trap.
      if (trap_valid) begin
         epc_d   = trap_pc;
         pc_d    = TRAP_VECTOR;
         flush_d = 1'b1;
      end else if (mret_valid) begin
         pc_d    = epc_q;
         flush_d = 1'b1;
      end else if (redirect_valid && tgt_misaligned) begin
         misaligned_d = 1'b1;
         epc_d        = redirect_target;
         pc_d         = TRAP_VECTOR;
         flush_d      = 1'b1;
      end else if (redirect_valid) begin
         pc_d    = redirect_target;
         flush_d = 1'b1;
      end else if (accept) begin
         pc_d = pc_q + STEP_INC;
      end
`else
      // A misaligned target is rejected outright: PC holds and nothing is flushed.
      if (redirect_valid && tgt_misaligned) begin
         misaligned_d = 1'b1;
      end else if (redirect_valid) begin
         pc_d    = redirect_target;
         flush_d = 1'b1;
      end else if (accept) begin
         pc_d = pc_q + STEP_INC;
      end
`endif

      // In RUN a request is always outstanding, so halt waits for its acceptance.
      case (state_q)
         S_BOOT:  state_d = halt ? S_HALT : S_RUN;
         S_RUN:   if (halt && accept) state_d = S_HALT;
         S_HALT:  if (!halt) state_d = S_RUN;
         default: state_d = S_BOOT;
      endcase

      fetch_valid_d = (state_d == S_RUN);
      halted_d      = (state_d == S_HALT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_BOOT;
         pc_q          <= RESET_VECTOR;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
         halted_q      <= 1'b0;
         misaligned_q  <= 1'b0;
`ifdef PC_TRAP_EN
         epc_q         <= '0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_valid_q <= fetch_valid_d;
         flush_q       <= flush_d;
         halted_q      <= halted_d;
         misaligned_q  <= misaligned_d;
`ifdef PC_TRAP_EN
         epc_q         <= epc_d;
`endif
      end
   end

   assign fetch_valid = fetch_valid_q;
   assign fetch_addr  = pc_q;
   assign flush       = flush_q;
   assign halted      = halted_q;
   assign misaligned  = misaligned_q;
`ifdef PC_TRAP_EN
   assign epc         = epc_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit; trap checks compile in with PC_TRAP_EN.
module tb_pc_fetch_unit;
   localparam int XLEN = 32;
`ifdef PC_TRAP_EN
   localparam bit TE = 1'b1;
`else
   localparam bit TE = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            fetch_ready = 1'b0;
   logic            redirect_valid = 1'b0;
   logic            halt = 1'b0;
   logic [XLEN-1:0] redirect_target = '0;
   logic            fetch_valid, flush, halted, misaligned;
   logic [XLEN-1:0] fetch_addr;
`ifdef PC_TRAP_EN
   logic            trap_valid = 1'b0;
   logic            mret_valid = 1'b0;
   logic [XLEN-1:0] trap_pc = '0;
   logic [XLEN-1:0] epc;
`endif

   typedef struct packed {
      logic            v;
      logic [XLEN-1:0] a;
      logic            f;
      logic            h;
      logic            m;
   } exp_t;

   exp_t sb[$];
   int   nvec = 0;
   int   nerr = 0;

   pc_fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .fetch_valid     (fetch_valid),
      .fetch_ready     (fetch_ready),
      .fetch_addr      (fetch_addr),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .flush           (flush),
      .halt            (halt),
      .halted          (halted),
      .misaligned      (misaligned)
`ifdef PC_TRAP_EN
      ,
      .trap_valid      (trap_valid),
      .trap_pc         (trap_pc),
      .mret_valid      (mret_valid),
      .epc             (epc)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input exp_t e);
      chk({tag, ".fetch_valid"}, XLEN'(fetch_valid), XLEN'(e.v));
      chk({tag, ".fetch_addr"},  fetch_addr,         e.a);
      chk({tag, ".flush"},       XLEN'(flush),       XLEN'(e.f));
      chk({tag, ".halted"},      XLEN'(halted),      XLEN'(e.h));
      chk({tag, ".misaligned"},  XLEN'(misaligned),  XLEN'(e.m));
   endtask

   // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
   task automatic step(input string tag, input logic rdy, input logic rv,
                       input logic [XLEN-1:0] tgt, input logic hl,
                       input logic ev, input logic [XLEN-1:0] ea,
                       input logic ef, input logic eh, input logic em);
      exp_t e;
      fetch_ready     = rdy;
      redirect_valid  = rv;
      redirect_target = tgt;
      halt            = hl;
      sb.push_back('{v: ev, a: ea, f: ef, h: eh, m: em});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_outs(tag, e);
      redirect_valid = 1'b0;
`ifdef PC_TRAP_EN
      trap_valid = 1'b0;
      mret_valid = 1'b0;
`endif
   endtask

   task automatic reset_dut();
      exp_t z;
      z = '0;
      reset          = 1'b0;
      fetch_ready    = 1'b0;
      redirect_valid = 1'b0;
      halt           = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_outs("reset", z);
`ifdef PC_TRAP_EN
      chk("reset.epc", epc, '0);
`endif
      reset = 1'b1;
      #1;
      chk_outs("boot", z);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_dut();
      // sequential fetch after reset release
      step("seq0", 1, 0, '0, 0, 1, 32'h0,  0, 0, 0);
      step("seq1", 1, 0, '0, 0, 1, 32'h4,  0, 0, 0);
      step("seq2", 1, 0, '0, 0, 1, 32'h8,  0, 0, 0);
      step("seq3", 1, 0, '0, 0, 1, 32'hC,  0, 0, 0);
      step("seq4", 1, 0, '0, 0, 1, 32'h10, 0, 0, 0);
      // backpressure holds PC
      for (int i = 0; i < 3; i++)
         step("stall", 0, 0, '0, 0, 1, 32'h10, 0, 0, 0);
      step("accept", 1, 0, '0, 0, 1, 32'h14, 0, 0, 0);
      // redirect under backpressure, then with a same-cycle accept
      step("redir",  0, 1, 32'h200, 0, 1, 32'h200, 1, 0, 0);
      step("redir1", 0, 0, '0,      0, 1, 32'h200, 0, 0, 0);
      step("redir2", 1, 0, '0,      0, 1, 32'h204, 0, 0, 0);
      step("redacc", 1, 1, 32'h300, 0, 1, 32'h300, 1, 0, 0);
      step("redac1", 1, 0, '0,      0, 1, 32'h304, 0, 0, 0);
      // misaligned target
      step("misal", 0, 1, 32'h202, 0, 1, TE ? 32'h100 : 32'h304, TE, 0, 1);
`ifdef PC_TRAP_EN
      chk("misal.epc", epc, 32'h202);
`endif
      step("realign", 0, 1, 32'h1000, 0, 1, 32'h1000, 1, 0, 0);
      // halt while stalled: request stays valid until accepted
      step("hstall0", 0, 0, '0, 1, 1, 32'h1000, 0, 0, 0);
      step("hstall1", 0, 0, '0, 1, 1, 32'h1000, 0, 0, 0);
      step("hacc",    1, 0, '0, 1, 0, 32'h1004, 0, 1, 0);
      step("hhold",   1, 0, '0, 1, 0, 32'h1004, 0, 1, 0);
      step("hredir",  0, 1, 32'hFFFF_FFF8, 1, 0, 32'hFFFF_FFF8, 1, 1, 0);
      step("resume",  0, 0, '0, 0, 1, 32'hFFFF_FFF8, 0, 0, 0);
      step("wrap0",   1, 0, '0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
      step("wrap1",   1, 0, '0, 0, 1, 32'h0, 0, 0, 0);
      step("wrap2",   1, 0, '0, 0, 1, 32'h4, 0, 0, 0);
      // asynchronous reset mid-request drops it at once
      reset = 1'b0;
      #1;
      chk("midrst.fetch_valid", XLEN'(fetch_valid), '0);
      chk("midrst.fetch_addr",  fetch_addr,         '0);
      // halt held through BOOT goes straight to HALT
      reset_dut();
      step("bhalt",  1, 0, '0, 1, 0, 32'h0, 0, 1, 0);
      step("brun",   1, 0, '0, 0, 1, 32'h0, 0, 0, 0);
      step("brun1",  1, 0, '0, 0, 1, 32'h4, 0, 0, 0);
      // redirect taken during BOOT
      reset_dut();
      step("bredir",  1, 1, 32'h80, 0, 1, 32'h80, 1, 0, 0);
      step("bredir1", 1, 0, '0,     0, 1, 32'h84, 0, 0, 0);
`ifdef PC_TRAP_EN
      // trap outranks a simultaneous redirect; mret outranks redirect
      trap_valid = 1'b1;
      trap_pc    = 32'h40;
      step("trap",  0, 1, 32'h500, 0, 1, 32'h100, 1, 0, 0);
      chk("trap.epc", epc, 32'h40);
      step("trap1", 1, 0, '0, 0, 1, 32'h104, 0, 0, 0);
      mret_valid = 1'b1;
      step("mret",  0, 1, 32'h600, 0, 1, 32'h40, 1, 0, 0);
      step("mret1", 1, 0, '0, 0, 1, 32'h44, 0, 0, 0);
      chk("mret.epc", epc, 32'h40);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Parametrised program-counter and fetch-request generator; successor to the single-step PC. Holds the architectural fetch PC, issues one instruction-fetch request per cycle to instruction memory over a valid/ready handshake, and applies redirects, halts and (optionally) trap entry/return with a fixed priority. Sits between the execute/branch stage (redirect source) and the instruction memory port.

## Interface
Parameters:
- XLEN, 32, address width in bits (≥ 16).
- RESET_VECTOR, 0, PC value loaded on reset; must be STEP-aligned.
- STEP, 4, byte increment per accepted fetch (2 or 4).
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry (PC_TRAP_EN only).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- fetch_valid  output  1  fetch request valid.
- fetch_ready  input  1  instruction memory accepts request.
- fetch_addr  output  XLEN  address of current request (= PC).
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  XLEN  new PC.
- flush  output  1  one-cycle pulse: in-flight fetches are stale.
- halt  input  1  stop issuing requests.
- halted  output  1  unit idle in HALT.
- misaligned  output  1  one-cycle pulse: redirect target not STEP-aligned.
- trap_valid  input  1  enter trap (PC_TRAP_EN only).
- trap_pc  input  XLEN  faulting PC to save (PC_TRAP_EN only).
- mret_valid  input  1  return from trap (PC_TRAP_EN only).
- epc  output  XLEN  saved exception PC (PC_TRAP_EN only).

## Operation
- States: BOOT, RUN, HALT.
- Reset (async assert, low): PC=RESET_VECTOR, state=BOOT, fetch_valid=0, flush=0, halted=0, misaligned=0, epc=0.
- BOOT: one cycle after reset release, fetch_valid=0; then RUN (or HALT if halt=1).
- RUN: fetch_valid=1, fetch_addr=PC. On fetch_valid&&fetch_ready with no redirect-class event: PC <= PC+STEP, modulo 2^XLEN (wraps to 0, no flag).
- Backpressure: while fetch_ready=0, PC and fetch_addr hold; the only legal change of fetch_addr under an unaccepted request is a redirect-class event.
- Redirect-class events, priority trap_valid > mret_valid > redirect_valid; the lower ones are ignored that cycle:
  - redirect: PC <= redirect_target; flush=1 next cycle. Any request accepted in the same cycle is stale.
  - misaligned target (low log2(STEP) bits ≠ 0): PC unchanged, misaligned=1 for one cycle, flush=0; with PC_TRAP_EN, treated as trap entry with epc <= redirect_target.
- halt=1 in RUN: if request is pending and not accepted, keep fetch_valid=1 until accepted, then HALT; if none pending, HALT next cycle. HALT: fetch_valid=0, halted=1, PC holds; halt=0 -> RUN next cycle.
- Redirect-class events are accepted in HALT and BOOT (PC updates, flush pulses, state unchanged).

## Timing
- Registered outputs; fetch_addr valid same cycle as fetch_valid.
- PC update latency: 1 cycle after accept or redirect.
- Steady-state throughput: one request per cycle while fetch_ready=1.
- flush asserts in the cycle the new PC first appears on fetch_addr.
- Reset asserted mid-request: request dropped immediately; no completion obligation.

## Configuration
- PC_TRAP_EN defined: trap_valid/trap_pc/mret_valid/epc present; trap sets epc<=trap_pc, PC<=TRAP_VECTOR, flush; mret sets PC<=epc, flush; misaligned redirect traps.
- PC_TRAP_EN undefined: those ports absent, epc logic removed; misaligned only pulses the flag and PC holds.

## Test plan
- Reset release, fetch_ready=1 -> cycle 1 fetch_valid=0; then fetch_addr 0x0, 0x4, 0x8, … one per cycle.
- fetch_ready=0 for 3 cycles at PC=0x10 -> fetch_addr stays 0x10, PC 0x14 after accept.
- redirect_valid with target 0x200 under backpressure -> next cycle fetch_addr=0x200, flush=1 for one cycle.
- redirect target 0x202 (STEP=4) -> misaligned pulse; without PC_TRAP_EN PC unchanged; with it, PC=0x100, epc=0x202.
- PC_TRAP_EN: trap_valid+redirect_valid together, trap_pc=0x40 -> PC=0x100, epc=0x40; later mret_valid -> PC=0x40.
- halt while request stalled -> fetch_valid held until fetch_ready, then halted=1; PC=0xFFFF_FFFC accepted after resume -> wraps to 0x0.
